// File: rtl/rs_generic.sv
// Reservation station for one functional unit: holds renamed micro-ops, snoops the
// CDB for operand wakeup, and dispatches the oldest ready entry through a registered output stage.
module rs_generic #(
  parameter int unsigned ENTRIES = 4,
  parameter int unsigned ROB_W   = 4,
  parameter int unsigned OP_W    = 5,
  parameter int unsigned DW      = 32,
  parameter int unsigned NCDB    = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rollback,
  input  logic                        issue_valid,
  output logic                        issue_ready,
  input  logic [OP_W-1:0]             issue_op,
  input  logic [DW-1:0]               issue_vj,
  input  logic [DW-1:0]               issue_vk,
  input  logic [ROB_W-1:0]            issue_qj,
  input  logic [ROB_W-1:0]            issue_qk,
  input  logic [ROB_W-1:0]            issue_dest,
  input  logic [NCDB*ROB_W-1:0]       cdb_tag,
  input  logic [NCDB*DW-1:0]          cdb_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [OP_W-1:0]             out_op,
  output logic [DW-1:0]               out_vj,
  output logic [DW-1:0]               out_vk,
  output logic [ROB_W-1:0]            out_dest,
  output logic [$clog2(ENTRIES):0]    count
);

  localparam int unsigned IW = $clog2(ENTRIES);
  localparam int unsigned CW = IW + 1;

  logic [ENTRIES-1:0] busy;
  logic [OP_W-1:0]    e_op   [ENTRIES];
  logic [DW-1:0]      e_vj   [ENTRIES];
  logic [DW-1:0]      e_vk   [ENTRIES];
  logic [ROB_W-1:0]   e_qj   [ENTRIES];
  logic [ROB_W-1:0]   e_qk   [ENTRIES];
  logic [ROB_W-1:0]   e_dest [ENTRIES];
  // age[i][j] set means entry i was allocated after entry j
  logic [ENTRIES-1:0] age    [ENTRIES];

  logic [ENTRIES-1:0] ready;
  logic               alloc;
  logic               load;
  logic               sel_valid;
  logic               free_found;
  logic [IW-1:0]      sel_idx;
  logic [IW-1:0]      alloc_idx;
  logic [DW:0]        byp_j;
  logic [DW:0]        byp_k;
  logic [DW:0]        wake_j [ENTRIES];
  logic [DW:0]        wake_k [ENTRIES];

  // Returns {hit, data} for the lowest CDB channel carrying a nonzero tag q.
  function automatic logic [DW:0] cdb_lookup(input logic [ROB_W-1:0]      q,
                                             input logic [NCDB*ROB_W-1:0] tags,
                                             input logic [NCDB*DW-1:0]    data);
    logic [DW:0] r;
    r = '0;
    for (int c = 0; c < NCDB; c++) begin
      if (!r[DW] && q != '0 && tags[c*ROB_W +: ROB_W] == q) begin
        r = {1'b1, data[c*DW +: DW]};
      end
    end
    return r;
  endfunction

  assign issue_ready = (count != CW'(ENTRIES));
  assign alloc       = issue_valid && issue_ready && (issue_op != '0);
  assign load        = !out_valid || out_ready;

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      ready[i] = busy[i] && (e_qj[i] == '0) && (e_qk[i] == '0);
    end
  end

  // Oldest ready entry: ready and younger than no other ready entry.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (!sel_valid && ready[i] && ((age[i] & ready) == '0)) begin
        sel_valid = 1'b1;
        sel_idx   = IW'(i);
      end
    end
  end

  always_comb begin
    free_found = 1'b0;
    alloc_idx  = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (!free_found && !busy[i]) begin
        free_found = 1'b1;
        alloc_idx  = IW'(i);
      end
    end
  end

  always_comb begin
    byp_j = cdb_lookup(issue_qj, cdb_tag, cdb_data);
    byp_k = cdb_lookup(issue_qk, cdb_tag, cdb_data);
    for (int e = 0; e < ENTRIES; e++) begin
      wake_j[e] = cdb_lookup(e_qj[e], cdb_tag, cdb_data);
      wake_k[e] = cdb_lookup(e_qk[e], cdb_tag, cdb_data);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || rollback) begin
      busy      <= '0;
      out_valid <= 1'b0;
      out_op    <= '0;
      out_vj    <= '0;
      out_vk    <= '0;
      out_dest  <= '0;
      count     <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        age[i] <= '0;
      end
    end else begin
      for (int e = 0; e < ENTRIES; e++) begin
        if (busy[e] && wake_j[e][DW]) begin
          e_vj[e] <= wake_j[e][DW-1:0];
          e_qj[e] <= '0;
        end
        if (busy[e] && wake_k[e][DW]) begin
          e_vk[e] <= wake_k[e][DW-1:0];
          e_qk[e] <= '0;
        end
      end

      if (load) begin
        out_valid <= sel_valid;
        if (sel_valid) begin
          out_op        <= e_op[sel_idx];
          out_vj        <= e_vj[sel_idx];
          out_vk        <= e_vk[sel_idx];
          out_dest      <= e_dest[sel_idx];
          busy[sel_idx] <= 1'b0;
        end
      end

      // A slot freed by dispatch this edge is never the allocated one: alloc uses registered busy.
      if (alloc) begin
        busy[alloc_idx]   <= 1'b1;
        e_op[alloc_idx]   <= issue_op;
        e_dest[alloc_idx] <= issue_dest;
        e_vj[alloc_idx]   <= byp_j[DW] ? byp_j[DW-1:0] : issue_vj;
        e_qj[alloc_idx]   <= byp_j[DW] ? '0 : issue_qj;
        e_vk[alloc_idx]   <= byp_k[DW] ? byp_k[DW-1:0] : issue_vk;
        e_qk[alloc_idx]   <= byp_k[DW] ? '0 : issue_qk;
        for (int i = 0; i < ENTRIES; i++) begin
          age[i][alloc_idx] <= 1'b0;
        end
        age[alloc_idx] <= busy;
      end

      count <= count + CW'(alloc) - CW'(load && sel_valid);
    end
  end

endmodule

// File: tb/tb_rs_generic.sv
// Bench for rs_generic: directed scenarios plus random traffic checked against an
// in-order queue model of the reservation station.
module tb_rs_generic;

  localparam int unsigned ENTRIES = 4;
  localparam int unsigned ROB_W   = 4;
  localparam int unsigned OP_W    = 5;
  localparam int unsigned DW      = 32;
  localparam int unsigned NCDB    = 3;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  rollback;
  logic                  issue_valid;
  logic                  issue_ready;
  logic [OP_W-1:0]       issue_op;
  logic [DW-1:0]         issue_vj;
  logic [DW-1:0]         issue_vk;
  logic [ROB_W-1:0]      issue_qj;
  logic [ROB_W-1:0]      issue_qk;
  logic [ROB_W-1:0]      issue_dest;
  logic [NCDB*ROB_W-1:0] cdb_tag;
  logic [NCDB*DW-1:0]    cdb_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [OP_W-1:0]       out_op;
  logic [DW-1:0]         out_vj;
  logic [DW-1:0]         out_vk;
  logic [ROB_W-1:0]      out_dest;
  logic [2:0]            count;

  rs_generic #(.ENTRIES(ENTRIES), .ROB_W(ROB_W), .OP_W(OP_W), .DW(DW), .NCDB(NCDB)) dut (
    .clk(clk), .rst(rst), .rollback(rollback),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_vj(issue_vj), .issue_vk(issue_vk), .issue_qj(issue_qj), .issue_qk(issue_qk),
    .issue_dest(issue_dest), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
    .out_vj(out_vj), .out_vk(out_vk), .out_dest(out_dest), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OP_W-1:0]  op;
    logic [DW-1:0]    vj;
    logic [DW-1:0]    vk;
    logic [ROB_W-1:0] qj;
    logic [ROB_W-1:0] qk;
    logic [ROB_W-1:0] dest;
  } ent_t;

  // Model: entries kept oldest-first, so the oldest ready one is the first ready in the queue.
  ent_t             mq[$];
  logic             m_ov   = 1'b0;
  logic [OP_W-1:0]  m_op   = '0;
  logic [DW-1:0]    m_vj   = '0;
  logic [DW-1:0]    m_vk   = '0;
  logic [ROB_W-1:0] m_dest = '0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void bus_lookup(input logic [ROB_W-1:0] q, output logic hit,
                                     output logic [DW-1:0] d);
    hit = 1'b0;
    d   = '0;
    if (q != '0) begin
      for (int c = 0; c < NCDB; c++) begin
        if (!hit && cdb_tag[c*ROB_W +: ROB_W] == q) begin
          hit = 1'b1;
          d   = cdb_data[c*DW +: DW];
        end
      end
    end
  endfunction

  function automatic void model_step();
    int sel;
    int pre;
    logic h;
    logic [DW-1:0] d;
    ent_t n;
    if (rst || rollback) begin
      mq.delete();
      m_ov = 1'b0; m_op = '0; m_vj = '0; m_vk = '0; m_dest = '0;
    end else begin
      sel = -1;
      pre = mq.size();
      if (!m_ov || out_ready) begin
        foreach (mq[i]) if (sel < 0 && mq[i].qj == '0 && mq[i].qk == '0) sel = i;
        m_ov = (sel >= 0);
        if (sel >= 0) begin
          m_op = mq[sel].op; m_vj = mq[sel].vj; m_vk = mq[sel].vk; m_dest = mq[sel].dest;
        end
      end
      foreach (mq[i]) begin
        bus_lookup(mq[i].qj, h, d);
        if (h) begin mq[i].vj = d; mq[i].qj = '0; end
        bus_lookup(mq[i].qk, h, d);
        if (h) begin mq[i].vk = d; mq[i].qk = '0; end
      end
      if (sel >= 0) mq.delete(sel);
      if (issue_valid && pre != int'(ENTRIES) && issue_op != '0) begin
        n.op = issue_op; n.dest = issue_dest;
        bus_lookup(issue_qj, h, d);
        n.vj = h ? d : issue_vj;
        n.qj = h ? '0 : issue_qj;
        bus_lookup(issue_qk, h, d);
        n.vk = h ? d : issue_vk;
        n.qk = h ? '0 : issue_qk;
        mq.push_back(n);
      end
    end
  endfunction

  // One clock: check pre-edge issue_ready, advance model, check registered outputs after the edge.
  task automatic cycle();
    chk("issue_ready", 64'(issue_ready), 64'(mq.size() != int'(ENTRIES)));
    model_step();
    @(posedge clk);
    #1;
    chk("out_valid", 64'(out_valid), 64'(m_ov));
    chk("count", 64'(count), 64'(mq.size()));
    if (m_ov) begin
      chk("out_op", 64'(out_op), 64'(m_op));
      chk("out_vj", 64'(out_vj), 64'(m_vj));
      chk("out_vk", 64'(out_vk), 64'(m_vk));
      chk("out_dest", 64'(out_dest), 64'(m_dest));
    end
  endtask

  task automatic issue(input logic [OP_W-1:0] op, input logic [DW-1:0] vj, input logic [DW-1:0] vk,
                       input logic [ROB_W-1:0] qj, input logic [ROB_W-1:0] qk,
                       input logic [ROB_W-1:0] dest);
    issue_valid = 1'b1; issue_op = op; issue_vj = vj; issue_vk = vk;
    issue_qj = qj; issue_qk = qk; issue_dest = dest;
  endtask

  task automatic idle();
    issue_valid = 1'b0; issue_op = '0; issue_vj = '0; issue_vk = '0;
    issue_qj = '0; issue_qk = '0; issue_dest = '0;
    cdb_tag = '0; cdb_data = '0;
  endtask

  initial begin
    rst = 1'b1; rollback = 1'b0; out_ready = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_op", 64'(out_op), 64'd0);
    chk("rst_out_vj", 64'(out_vj), 64'd0);
    chk("rst_out_vk", 64'(out_vk), 64'd0);
    chk("rst_out_dest", 64'(out_dest), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_issue_ready", 64'(issue_ready), 64'd1);

    // 1: two-cycle issue-to-dispatch latency
    issue(5'd1, 32'd5, 32'd7, 4'd0, 4'd0, 4'd3);
    cycle();
    chk("t1_not_yet", 64'(out_valid), 64'd0);
    idle();
    cycle();
    chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_vj", 64'(out_vj), 64'd5);
    chk("t1_vk", 64'(out_vk), 64'd7);
    chk("t1_dest", 64'(out_dest), 64'd3);
    chk("t1_count", 64'(count), 64'd0);
    cycle();

    // 2: younger ready op overtakes a waiting one; wakeup on channel 2
    issue(5'd2, 32'd0, 32'd9, 4'd6, 4'd0, 4'd2);
    cycle();
    issue(5'd3, 32'd1, 32'd2, 4'd0, 4'd0, 4'd4);
    cycle();
    idle();
    cycle();
    chk("t2_first_dest", 64'(out_dest), 64'd4);
    cdb_tag = {4'd6, 4'd0, 4'd0};
    cdb_data = {32'hAB, 32'h0, 32'h0};
    cycle();
    idle();
    cycle();
    chk("t2_second_dest", 64'(out_dest), 64'd2);
    chk("t2_second_vj", 64'(out_vj), 64'hAB);
    cycle();

    // 3: issue-cycle bypass from channel 0
    issue(5'd4, 32'd3, 32'd0, 4'd0, 4'd9, 4'd8);
    cdb_tag = {4'd0, 4'd0, 4'd9};
    cdb_data = {32'h0, 32'h0, 32'h11};
    cycle();
    idle();
    cycle();
    chk("t3_valid", 64'(out_valid), 64'd1);
    chk("t3_vk", 64'(out_vk), 64'h11);
    cycle();

    // 4: fill under backpressure, hold, then drain in order
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      issue(OP_W'(i + 1), DW'(100 + i), DW'(200 + i), 4'd0, 4'd0, ROB_W'(i + 1));
      cycle();
    end
    chk("t4_full_count", 64'(count), 64'd4);
    chk("t4_full_ready", 64'(issue_ready), 64'd0);
    chk("t4_head_dest", 64'(out_dest), 64'd1);
    idle();
    repeat (5) cycle();
    chk("t4_hold_dest", 64'(out_dest), 64'd1);
    out_ready = 1'b1;
    repeat (6) cycle();

    // 5: simultaneous wakeup on all channels; dispatch oldest-first
    issue(5'd7, 32'd0, 32'd1, 4'd1, 4'd0, 4'd5);
    cycle();
    issue(5'd8, 32'd0, 32'd2, 4'd2, 4'd0, 4'd6);
    cycle();
    issue(5'd9, 32'd3, 32'd0, 4'd0, 4'd3, 4'd7);
    cycle();
    idle();
    cdb_tag = {4'd3, 4'd2, 4'd1};
    cdb_data = {32'h33, 32'h22, 32'h11};
    cycle();
    idle();
    cycle();
    chk("t5_dest0", 64'(out_dest), 64'd5);
    cycle();
    chk("t5_dest1", 64'(out_dest), 64'd6);
    cycle();
    chk("t5_dest2", 64'(out_dest), 64'd7);
    chk("t5_vk2", 64'(out_vk), 64'h33);
    cycle();

    // 6: rollback with occupied entries and a valid output
    out_ready = 1'b0;
    issue(5'd10, 32'd1, 32'd1, 4'd0, 4'd0, 4'd9);
    cycle();
    issue(5'd11, 32'd1, 32'd1, 4'd0, 4'd12, 4'd10);
    cycle();
    issue(5'd12, 32'd1, 32'd1, 4'd0, 4'd0, 4'd11);
    cycle();
    issue(5'd13, 32'd1, 32'd1, 4'd13, 4'd0, 4'd12);
    cycle();
    chk("t6_pre_count", 64'(count), 64'd3);
    idle();
    rollback = 1'b1;
    out_ready = 1'b1;
    cdb_tag = {4'd13, 4'd12, 4'd0};
    cdb_data = {32'h5, 32'h6, 32'h0};
    cycle();
    chk("t6_count", 64'(count), 64'd0);
    chk("t6_valid", 64'(out_valid), 64'd0);
    rollback = 1'b0;
    idle();
    repeat (2) cycle();

    // Random traffic
    for (int n = 0; n < 500; n++) begin
      issue_valid = 1'($urandom_range(0, 1));
      issue_op    = ($urandom_range(0, 7) == 0) ? '0 : OP_W'($urandom_range(1, 31));
      issue_vj    = DW'($urandom());
      issue_vk    = DW'($urandom());
      issue_qj    = ($urandom_range(0, 1) == 0) ? '0 : ROB_W'($urandom_range(1, 15));
      issue_qk    = ($urandom_range(0, 1) == 0) ? '0 : ROB_W'($urandom_range(1, 15));
      issue_dest  = ROB_W'($urandom_range(1, 15));
      for (int c = 0; c < NCDB; c++) begin
        cdb_tag[c*ROB_W +: ROB_W] = ($urandom_range(0, 2) == 0) ? '0 : ROB_W'($urandom_range(1, 15));
        cdb_data[c*DW +: DW]      = DW'($urandom());
      end
      out_ready = ($urandom_range(0, 3) != 0);
      rollback  = ($urandom_range(0, 60) == 0);
      cycle();
    end
    rollback = 1'b0;
    idle();
    out_ready = 1'b1;
    repeat (6) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
